// File: rtl/picorv32_dma_pkg.sv
// Shared types and constants for the picorv32 memory copy engine.
// Contents: FSM state enum, word/strobe constants, word-align helper.
// No ports (package).
package picorv32_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RGAP,
    WR,
    WGAP,
    DONE
  } state_e;

  localparam logic [31:0] WORD_BYTES = 32'd4;
  localparam logic [3:0]  STRB_WORD  = 4'hf;
  localparam logic [31:0] ALIGN_MASK = 32'hffff_fffc;

  // Byte address -> word address (low two bits forced to zero).
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/picorv32_dma_watchdog.sv
// Stall watchdog: counts consecutive cycles a request waits for mem_ready.
// Ports: clk, reset (sync, active-high), en (request stalled this cycle),
//        clr (handshake or no request), expired (stall limit reached this cycle).
module picorv32_dma_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // Count value seen during the last permitted stall cycle.
  localparam logic [CW-1:0] LAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // A zero limit disables the watchdog entirely.
  assign expired = (TIMEOUT_CYCLES != 0) && en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/picorv32_mem_dma.sv
// Word copy engine acting as initiator on the picorv32 native memory bus.
// Ports: clk/reset; control start/abort/cfg_src/cfg_dst/cfg_len; status busy/done/
//        error/words_done; bus mem_valid/mem_instr/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata.
module picorv32_mem_dma
  import picorv32_dma_pkg::*;
#(
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [31:0]          cfg_src,
  input  logic [31:0]          cfg_dst,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [LEN_WIDTH-1:0] words_done,
  output logic                 mem_valid,
  output logic                 mem_instr,
  input  logic                 mem_ready,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic [3:0]           mem_wstrb,
  input  logic [31:0]          mem_rdata
);

  state_e               state_q, state_d;
  logic [31:0]          src_q, src_d;
  logic [31:0]          dst_q, dst_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic [LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0] words_q, words_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 error_q, error_d;
  logic                 abort_q, abort_d;

  logic hs;
  logic abort_now;
  logic wd_en;
  logic wd_clr;
  logic wd_expired;

  assign hs        = valid_q && mem_ready;
  // An abort seen while a request is outstanding is remembered until its handshake.
  assign abort_now = abort || abort_q;
  assign wd_en     = valid_q && !mem_ready;
  assign wd_clr    = !valid_q || mem_ready;

  picorv32_dma_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .en     (wd_en),
    .clr    (wd_clr),
    .expired(wd_expired)
  );

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    len_d   = len_q;
    words_d = words_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    abort_d = abort_q;

    if (abort && (state_q == RD || state_q == WR)) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        // done_q high means this is the completion cycle: a start here is dropped.
        if (start && !abort && !done_q) begin
          src_d   = word_align(cfg_src);
          dst_d   = word_align(cfg_dst);
          len_d   = cfg_len;
          words_d = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          abort_d = 1'b0;
          if (cfg_len != '0) begin
            state_d = RD;
            valid_d = 1'b1;
            addr_d  = word_align(cfg_src);
            wstrb_d = 4'h0;
          end else begin
            state_d = DONE;
          end
        end
      end

      RD: begin
        if (hs) begin
          wdata_d = mem_rdata;
          src_d   = src_q + WORD_BYTES;
          valid_d = 1'b0;
          if (abort_now) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            abort_d = 1'b0;
          end else begin
            state_d = RGAP;
          end
        end else if (wd_expired) begin
          valid_d = 1'b0;
          error_d = 1'b1;
          abort_d = 1'b0;
          state_d = DONE;
        end
      end

      RGAP: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = WR;
          valid_d = 1'b1;
          addr_d  = dst_q;
          wstrb_d = STRB_WORD;
        end
      end

      WR: begin
        if (hs) begin
          dst_d   = dst_q + WORD_BYTES;
          words_d = words_q + 1'b1;
          valid_d = 1'b0;
          wstrb_d = 4'h0;
          if (abort_now) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            abort_d = 1'b0;
          end else begin
            state_d = WGAP;
          end
        end else if (wd_expired) begin
          valid_d = 1'b0;
          error_d = 1'b1;
          abort_d = 1'b0;
          state_d = DONE;
        end
      end

      WGAP: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (words_q == len_q) begin
          state_d = DONE;
        end else begin
          state_d = RD;
          valid_d = 1'b1;
          addr_d  = src_q;
          wstrb_d = 4'h0;
        end
      end

      DONE: begin
        // busy falls and done pulses on the same edge.
        done_d  = 1'b1;
        busy_d  = 1'b0;
        abort_d = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      len_q   <= '0;
      words_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      len_q   <= len_d;
      words_q <= words_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      abort_q <= abort_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign words_done = words_q;
  assign mem_valid  = valid_q;
  assign mem_instr  = 1'b0;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_wstrb  = wstrb_q;

endmodule

// File: tb/tb_picorv32_mem_dma.sv
// Directed bench for picorv32_mem_dma with a wait-state memory responder.
module tb_picorv32_mem_dma;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
  logic        busy, done, error;
  logic [15:0] words_done;
  logic        mem_valid, mem_instr;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = 32'h0;

  picorv32_mem_dma #(.LEN_WIDTH(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .busy(busy), .done(done), .error(error), .words_done(words_done),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // ---------------- memory responder and monitors ----------------
  bit [31:0]   mem [256];
  int          wait_n = 0;
  bit          never_ready = 1'b0;
  int          rsp_cnt = 0;
  logic        pk_en = 1'b0;
  logic [7:0]  pk_idx = 8'h0;
  logic [31:0] pk_val = 32'h0;
  logic [31:0] lg_addr[$], lg_data[$];
  logic [3:0]  lg_strb[$];

  always @(negedge clk) begin
    if (mem_valid !== 1'b1 || never_ready) begin
      mem_ready = 1'b0;
      rsp_cnt   = 0;
    end else if (!mem_ready) begin
      if (rsp_cnt >= wait_n) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
      end else begin
        rsp_cnt++;
      end
    end
  end

  always @(posedge clk) begin
    if (pk_en) mem[pk_idx] = pk_val;
    if (mem_valid === 1'b1 && mem_ready) begin
      lg_addr.push_back(mem_addr);
      lg_strb.push_back(mem_wstrb);
      lg_data.push_back(mem_wstrb == 4'hf ? mem_wdata : mem_rdata);
      if (mem_wstrb == 4'hf) mem[mem_addr[9:2]] = mem_wdata;
    end
  end

  int          done_cnt = 0, vhi_cnt = 0, stab_chk = 0, stab_bad = 0, gap_cnt = 0, gap_bad = 0;
  bit          prev_v = 1'b0, in_gap = 1'b0;
  int          gap_len = 0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (mem_valid === 1'b1) begin
      vhi_cnt++;
      if (prev_v) begin
        stab_chk++;
        if (mem_addr !== s_addr || mem_wdata !== s_wdata || mem_wstrb !== s_wstrb) stab_bad++;
      end
      s_addr = mem_addr; s_wdata = mem_wdata; s_wstrb = mem_wstrb;
      if (in_gap) begin
        gap_cnt++;
        if (gap_len != 1) gap_bad++;
        in_gap = 1'b0;
      end
    end else begin
      if (prev_v) begin in_gap = 1'b1; gap_len = 0; end
      if (in_gap) gap_len++;
    end
    if (busy !== 1'b1) in_gap = 1'b0;
    prev_v = (mem_valid === 1'b1);
  end

  // ---------------- checking helpers ----------------
  int vec = 0, miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int idx, input logic [31:0] v);
    pk_idx = idx[7:0];
    pk_val = v;
    pk_en  = 1'b1;
    tick();
    pk_en  = 1'b0;
  endtask

  task automatic wait_idle(input int maxc, input string tag);
    int n = 0;
    while (busy && n < maxc) begin tick(); n++; end
    chk(tag, busy, 1'b0);
  endtask

  function automatic logic [31:0] qa(input int i);
    return (i < lg_addr.size()) ? lg_addr[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] qd(input int i);
    return (i < lg_data.size()) ? lg_data[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [3:0] qs(input int i);
    return (i < lg_strb.size()) ? lg_strb[i] : 4'hx;
  endfunction

  // ---------------- directed sequence ----------------
  logic [31:0] t1_addr [6];
  logic [3:0]  t1_strb [6];
  logic [31:0] t1_data [6];

  initial begin
    int  base, d0, v0, s0, sb0, g0, gb0;
    bit  found;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    t1_addr = '{32'h100, 32'h200, 32'h104, 32'h204, 32'h108, 32'h208};
    t1_strb = '{4'h0, 4'hf, 4'h0, 4'hf, 4'h0, 4'hf};
    t1_data = '{32'h11111111, 32'h11111111, 32'h22222222, 32'h22222222, 32'h33333333, 32'h33333333};
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_valid", mem_valid, 1'b0);
    chk("rst_words", words_done, 16'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wstrb", mem_wstrb, 4'h0);
    chk("rst_instr", mem_instr, 1'b0);

    // 1. basic three-word copy, zero-wait responder
    poke(64, 32'h11111111); poke(65, 32'h22222222); poke(66, 32'h33333333);
    base = lg_addr.size(); d0 = done_cnt;
    cfg_src = 32'h100; cfg_dst = 32'h200; cfg_len = 16'd3;
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_busy", busy, 1'b1);
    chk("t1_valid", mem_valid, 1'b1);
    chk("t1_first_addr", mem_addr, 32'h100);
    chk("t1_first_strb", mem_wstrb, 4'h0);
    wait_idle(100, "t1_idle");
    chk("t1_done_at_idle", done, 1'b1);
    tick(); tick();
    chk("t1_done_cnt", done_cnt - d0, 1);
    chk("t1_words", words_done, 16'd3);
    chk("t1_nxfers", lg_addr.size() - base, 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t1_addr%0d", i), qa(base + i), t1_addr[i]);
      chk($sformatf("t1_strb%0d", i), qs(base + i), t1_strb[i]);
      chk($sformatf("t1_data%0d", i), qd(base + i), t1_data[i]);
    end
    chk("t1_mem200", mem[128], 32'h11111111);
    chk("t1_mem208", mem[130], 32'h33333333);

    // 2. zero length; start during the done cycle is dropped
    d0 = done_cnt; v0 = vhi_cnt;
    cfg_len = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_busy", busy, 1'b1);
    chk("t2_done_early", done, 1'b0);
    chk("t2_words_clr", words_done, 16'd0);
    tick();
    chk("t2_done", done, 1'b1);
    chk("t2_busy_off", busy, 1'b0);
    cfg_len = 16'd1;
    start = 1'b1; tick(); start = 1'b0;
    chk("t2_start_in_done", busy, 1'b0);
    tick(); tick();
    chk("t2_no_valid", vhi_cnt - v0, 0);
    chk("t2_done_cnt", done_cnt - d0, 1);

    // 3. five wait states per access
    wait_n = 5;
    poke(80, 32'hA5A5A5A5); poke(81, 32'h5A5A1234);
    base = lg_addr.size(); d0 = done_cnt; s0 = stab_chk; sb0 = stab_bad; g0 = gap_cnt; gb0 = gap_bad;
    cfg_src = 32'h140; cfg_dst = 32'h240; cfg_len = 16'd2;
    start = 1'b1; tick(); start = 1'b0;
    wait_idle(300, "t3_idle");
    tick(); tick();
    chk("t3_stall_cycles", stab_chk - s0, 20);
    chk("t3_unstable", stab_bad - sb0, 0);
    chk("t3_gaps", gap_cnt - g0, 3);
    chk("t3_bad_gaps", gap_bad - gb0, 0);
    chk("t3_mem240", mem[144], 32'hA5A5A5A5);
    chk("t3_mem244", mem[145], 32'h5A5A1234);
    chk("t3_words", words_done, 16'd2);
    chk("t3_done_cnt", done_cnt - d0, 1);
    chk("t3_nxfers", lg_addr.size() - base, 4);

    // 4. abort during the second read
    wait_n = 2;
    poke(67, 32'h44444444);
    base = lg_addr.size(); d0 = done_cnt;
    cfg_src = 32'h100; cfg_dst = 32'h300; cfg_len = 16'd4;
    start = 1'b1; tick(); start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mem_valid && mem_addr == 32'h104 && mem_wstrb == 4'h0) found = 1'b1;
      else tick();
    end
    chk("t4_second_read", found, 1'b1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("t4_hold_valid", mem_valid, 1'b1);
    wait_idle(50, "t4_idle");
    chk("t4_no_done", done, 1'b0);
    tick(); tick(); tick(); tick();
    chk("t4_valid_off", mem_valid, 1'b0);
    chk("t4_done_cnt", done_cnt - d0, 0);
    chk("t4_words", words_done, 16'd1);
    chk("t4_nxfers", lg_addr.size() - base, 3);
    chk("t4_last_addr", qa(base + 2), 32'h104);
    chk("t4_mem300", mem[192], 32'h11111111);
    chk("t4_mem304", mem[193], 32'h0);

    // 5. responder never ready
    never_ready = 1'b1;
    d0 = done_cnt; v0 = vhi_cnt;
    cfg_src = 32'h100; cfg_dst = 32'h380; cfg_len = 16'd1;
    start = 1'b1; tick(); start = 1'b0;
    wait_idle(100, "t5_idle");
    chk("t5_done", done, 1'b1);
    chk("t5_error", error, 1'b1);
    tick(); tick();
    chk("t5_valid_cycles", vhi_cnt - v0, 16);
    chk("t5_done_cnt", done_cnt - d0, 1);
    chk("t5_words", words_done, 16'd0);
    chk("t5_error_sticky", error, 1'b1);
    never_ready = 1'b0;
    cfg_len = 16'd0;
    start = 1'b1; tick(); start = 1'b0;
    chk("t5_error_clr", error, 1'b0);
    wait_idle(10, "t5_idle2");
    tick(); tick();

    // 6. source wrap, then reset during a write
    wait_n = 3;
    poke(255, 32'hDEADBEEF); poke(0, 32'hCAFEF00D);
    base = lg_addr.size();
    cfg_src = 32'hFFFFFFFC; cfg_dst = 32'h3C0; cfg_len = 16'd2;
    start = 1'b1; tick(); start = 1'b0;
    chk("t6_first_addr", mem_addr, 32'hFFFFFFFC);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (mem_valid && mem_addr == 32'h3C4 && mem_wstrb == 4'hf) found = 1'b1;
      else tick();
    end
    chk("t6_second_write", found, 1'b1);
    chk("t6_nxfers", lg_addr.size() - base, 3);
    chk("t6_wr0_addr", qa(base + 1), 32'h3C0);
    chk("t6_rd1_addr", qa(base + 2), 32'h0);
    chk("t6_rd1_data", qd(base + 2), 32'hCAFEF00D);
    chk("t6_mem3c0", mem[240], 32'hDEADBEEF);
    reset = 1'b1; tick();
    chk("t6_rst_valid", mem_valid, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_words", words_done, 16'd0);
    chk("t6_rst_wstrb", mem_wstrb, 4'h0);
    chk("t6_rst_addr", mem_addr, 32'h0);
    reset = 1'b0;
    tick(); tick(); tick();
    chk("t6_mem3c4", mem[241], 32'h0);
    chk("t6_idle_valid", mem_valid, 1'b0);

    chk("all_unstable", stab_bad, 0);
    chk("all_bad_gaps", gap_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
